// File: rtl/nested_loop_counter.sv
// nested_loop_counter: two-level index generator (inner fastest, outer slowest).
// A scan walks (inner,outer) from (0,0) up to (inner limit, outer limit), one
// beat per accepted en_i. done_o pulses the cycle after the terminal beat.
// Optional build macro NESTED_LOOP_COUNTER_RUNTIME_LIMIT_EN replaces the
// constant limits with inner_max_i/outer_max_i sampled at scan start.
module nested_loop_counter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned INNER_MAX = 10,
  parameter int unsigned OUTER_MAX = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 en_i,
  input  logic                 abort_i,
`ifdef NESTED_LOOP_COUNTER_RUNTIME_LIMIT_EN
  input  logic [WORD_SIZE-1:0] inner_max_i,
  input  logic [WORD_SIZE-1:0] outer_max_i,
`endif
  output logic [WORD_SIZE-1:0] inner_o,
  output logic [WORD_SIZE-1:0] outer_o,
  output logic                 busy_o,
  output logic                 last_o,
  output logic                 done_o
);

  // Elaboration-time guard: limits must be representable in WORD_SIZE bits.
  if (WORD_SIZE == 0) begin : g_bad_width
    $error("nested_loop_counter: WORD_SIZE must be at least 1");
  end
  if ((INNER_MAX >> WORD_SIZE) != 0) begin : g_bad_inner
    $error("nested_loop_counter: INNER_MAX does not fit in WORD_SIZE bits");
  end
  if ((OUTER_MAX >> WORD_SIZE) != 0) begin : g_bad_outer
    $error("nested_loop_counter: OUTER_MAX does not fit in WORD_SIZE bits");
  end

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e               state_q;
  logic [WORD_SIZE-1:0] inner_q;
  logic [WORD_SIZE-1:0] outer_q;
  logic                 done_q;
  logic [WORD_SIZE-1:0] inner_lim;
  logic [WORD_SIZE-1:0] outer_lim;
  logic                 inner_at_lim;
  logic                 last;

`ifdef NESTED_LOOP_COUNTER_RUNTIME_LIMIT_EN
  logic [WORD_SIZE-1:0] inner_lim_q;
  logic [WORD_SIZE-1:0] outer_lim_q;

  assign inner_lim = inner_lim_q;
  assign outer_lim = outer_lim_q;
`else
  assign inner_lim = WORD_SIZE'(INNER_MAX);
  assign outer_lim = WORD_SIZE'(OUTER_MAX);
`endif

  assign inner_at_lim = (inner_q == inner_lim);
  assign last         = (state_q == StCount) && inner_at_lim && (outer_q == outer_lim);

  // Scan FSM: state, indices, done pulse and (optionally) captured limits.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      inner_q     <= '0;
      outer_q     <= '0;
      done_q      <= 1'b0;
`ifdef NESTED_LOOP_COUNTER_RUNTIME_LIMIT_EN
      inner_lim_q <= '0;
      outer_lim_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          inner_q <= '0;
          outer_q <= '0;
          if (start_i) begin
            state_q <= StCount;
`ifdef NESTED_LOOP_COUNTER_RUNTIME_LIMIT_EN
            inner_lim_q <= inner_max_i;
            outer_lim_q <= outer_max_i;
`endif
          end
        end
        StCount: begin
          if (abort_i) begin
            // Abort wins over en_i/start_i and suppresses done_o.
            state_q <= StIdle;
            inner_q <= '0;
            outer_q <= '0;
          end else if (en_i) begin
            if (last) begin
              inner_q <= '0;
              outer_q <= '0;
              done_q  <= 1'b1;
              if (start_i) begin
                // Back-to-back scan: stay in COUNT, new scan begins at (0,0).
`ifdef NESTED_LOOP_COUNTER_RUNTIME_LIMIT_EN
                inner_lim_q <= inner_max_i;
                outer_lim_q <= outer_max_i;
`endif
              end else begin
                state_q <= StIdle;
              end
            end else if (inner_at_lim) begin
              inner_q <= '0;
              outer_q <= outer_q + WORD_SIZE'(1);
            end else begin
              inner_q <= inner_q + WORD_SIZE'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          inner_q <= '0;
          outer_q <= '0;
        end
      endcase
    end
  end

  assign inner_o = inner_q;
  assign outer_o = outer_q;
  assign busy_o  = (state_q == StCount);
  assign last_o  = last;
  assign done_o  = done_q;

endmodule

// File: doc/nested_loop_counter.md
NESTED_LOOP_COUNTER -- requirements
Module: nested_loop_counter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, width of each index output.
REQ-002 SHALL have parameter INNER_MAX, default 10, last inner index value (inclusive).
REQ-003 SHALL have parameter OUTER_MAX, default 3, last outer index value (inclusive).
REQ-004 SHALL have port clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_i  input  1  begin a scan; sampled in IDLE, or in COUNT on the terminal beat.
REQ-007 SHALL have port en_i  input  1  advance one beat when high in COUNT; hold when low.
REQ-008 SHALL have port abort_i  input  1  cancel scan in progress.
REQ-009 SHALL have port inner_o  output  WORD_SIZE  inner index.
REQ-010 SHALL have port outer_o  output  WORD_SIZE  outer index.
REQ-011 SHALL have port busy_o  output  1  high while in COUNT.
REQ-012 SHALL have port last_o  output  1  combinational; COUNT and inner_o==inner limit and outer_o==outer limit.
REQ-013 SHALL have port done_o  output  1  registered one-cycle pulse after the terminal beat is accepted.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, COUNT.
REQ-015 IDLE: indices held at 0; start_i high -> COUNT next cycle with indices 0, so first beat index is (0,0).
REQ-016 COUNT, en_i high, inner_o < inner limit: inner_o += 1, outer_o unchanged.
REQ-017 COUNT, en_i high, inner_o == inner limit, not last: inner_o -> 0, outer_o += 1.
REQ-018 COUNT, en_i high, last_o high (terminal beat): indices -> 0, done_o high next cycle; state -> IDLE, or stays COUNT if start_i is also high (back-to-back scan, no idle gap).
REQ-019 COUNT, en_i low: indices and state hold; start_i ignored.
REQ-020 abort_i high in COUNT: IDLE next cycle, indices 0, no done_o; abort_i has priority over en_i and start_i; ignored in IDLE.
REQ-021 start_i in COUNT on a non-terminal beat SHALL be ignored.
REQ-022 Indices SHALL never exceed their limits; no wrap beyond limit.
REQ-023 Limits SHALL be < 2**WORD_SIZE; elaboration SHALL fail otherwise (parameter mode).

Reset
REQ-024 reset_i high SHALL immediately, without clock, force IDLE, inner_o=0, outer_o=0, done_o=0; busy_o=0, last_o=0 follow.
REQ-025 Reset asserted mid-scan SHALL discard the scan; no done_o after release.
REQ-026 After release, the first start_i SHALL behave per REQ-015.

Configuration
REQ-027 Macro NESTED_LOOP_COUNTER_RUNTIME_LIMIT_EN SHALL select limit source.
REQ-028 Defined: adds inputs inner_max_i, outer_max_i (WORD_SIZE each); values captured into internal registers when a scan starts (REQ-015/REQ-018 restart) and used as limits for that scan; mid-scan changes ignored; reset clears captured limits to 0.
REQ-029 Undefined: no extra ports; limits are INNER_MAX/OUTER_MAX constants.

Verification
REQ-030 INNER_MAX=2, OUTER_MAX=1, en_i held high, start_i pulse -> (inner,outer) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) on consecutive cycles; last_o on (2,1); done_o one cycle after; busy_o low thereafter.
REQ-031 Same config, en_i low every other cycle -> each index held two cycles; total 12 COUNT cycles; done_o once.
REQ-032 start_i high on terminal beat -> next cycle busy_o=1, (0,0), done_o=1; second scan completes identically.
REQ-033 abort_i at (1,1) -> next cycle busy_o=0, (0,0); done_o stays 0.
REQ-034 reset_i asserted between clock edges at (2,0) -> outputs 0 immediately; no done_o after release; new start_i restarts from (0,0).
REQ-035 With NESTED_LOOP_COUNTER_RUNTIME_LIMIT_EN, inner_max_i=1, outer_max_i=0 at start, changed to 5 mid-scan -> sequence (0,0),(1,0) then done_o.
